handshake_protocol_monitor: RTL and testbench
=============================================

// Module: handshake_protocol_monitor
// PURPOSE
//  Synthesizable, multi-channel valid/ready protocol monitor.
//  Per channel, once valid is raised without ready it checks three rules until the handshake completes:
//   - valid stays high;
//   - data stays constant;
//   - optionally, ready arrives within a bounded stall.
//  Violations set sticky per-channel flags and bump a saturating counter; transfers are counted per channel.
//  Sits passively beside any stream interface for silicon/FPGA debug; it drives nothing on the bus.
// PARAMETERS
//  NUM_CH     4   number of independent valid/ready channels
//  DATA_W     32  payload width per channel
//  MAX_STALL  16  stall cycles before timeout flag; 0 disables timeout check
//  CNT_W      16  width of transfer and violation counters
// PORTS
//  clk              in   1               single clock, all logic on posedge
//  reset            in   1               synchronous, active-high
//  valid            in   NUM_CH          per-channel valid
//  ready            in   NUM_CH          per-channel ready
//  data             in   NUM_CH*DATA_W   payloads, ch i at [i*DATA_W +: DATA_W]
//  err_clear        in   1               clears sticky flags and viol_count
//  err_valid_drop   out  NUM_CH          sticky: valid deasserted before ready
//  err_data_change  out  NUM_CH          sticky: data changed while stalled
//  err_timeout      out  NUM_CH          sticky: stall reached MAX_STALL
//  err_any          out  1               OR of all sticky flags
//  xfer_count       out  NUM_CH*CNT_W    completed handshakes per ch, wraps
//  viol_count       out  CNT_W           total violation events, saturates at all-ones
// BEHAVIOUR
//  Reset: all FSMs IDLE, every output 0, snapshots and stall counters 0.
//   - Reset mid-stall abandons the episode without flagging.
//  Per-channel FSM, states IDLE and WAIT.
//   IDLE:
//    - valid&ready: transfer; xfer_count+1; stay IDLE.
//    - valid&!ready: capture data into snapshot; stall_cnt=1; go WAIT.
//    - !valid: stay IDLE.
//   WAIT, evaluated in this priority order:
//    1. !valid: valid-drop violation; go IDLE; data not checked.
//    2. valid & data!=snapshot: data-change violation; snapshot<=data.
//       - Further changes flag again; the flag is sticky anyway.
//    3. valid&ready: transfer; xfer_count+1; go IDLE.
//       - Counted even if rule 2 fired in the same cycle.
//    4. valid&!ready: stall_cnt+1, saturating at MAX_STALL.
//       - If MAX_STALL!=0 and stall_cnt==MAX_STALL before increment, raise a timeout violation.
//       - Timeout fires once per WAIT episode; stay WAIT.
//  Stall timing:
//   - The stall includes the entry cycle.
//   - Ready on stall cycle k (k<=MAX_STALL) is legal.
//   - Ready never arriving flags on the cycle after the MAX_STALL-th stalled cycle.
//  Latency: flags, counters and err_any update on the clock edge ending the violating/transfer cycle, i.e. visible the next cycle.
//   - err_any is the combinational OR of registered flags.
//  viol_count:
//   - adds the number of violation events that cycle (popcount over all channels and rule types);
//   - saturates, never wraps.
//  err_clear:
//   - zeroes sticky flags and viol_count; FSMs, snapshots and xfer_count unaffected.
//   - A violation in the same cycle as err_clear wins: flag set, viol_count = events that cycle.
//  Channels fully independent; simultaneous events on different channels all recorded.
// TESTING
//  T1 ch0: valid=1, ready=0 for 3 cycles, data=0xA5A5_0001 constant, then ready=1
//     -> xfer_count[0]=1, no flags, viol_count=0.
//  T2 ch1: valid=1, ready=0, data 0x10 then 0x11 on 2nd cycle, ready on 4th
//     -> err_data_change[1]=1, viol_count=1, xfer_count[1]=1, err_any=1.
//  T3 ch2: valid=1, ready=0 one cycle, then valid=0
//     -> err_valid_drop[2]=1 next cycle; FSM IDLE; new valid restarts episode.
//  T4 ch3: MAX_STALL=16, valid=1, ready=0 for 20 cycles
//     -> err_timeout[3] rises after 16th stall cycle, viol_count=1 (not 4).
//     Repeat with ready on stall cycle 16 -> no timeout.
//  T5 ch0 and ch1 drop valid in the same cycle that err_clear=1 (prior viol_count=5)
//     -> both drop flags set, viol_count=2.
//  T6 ch0 mid-stall: assert reset one cycle, then back-to-back valid&ready for 4 cycles
//     -> no flags, xfer_count[0]=4.

Source files
------------

// File: rtl/handshake_protocol_monitor.sv
// ---------------------------------------------------------------------------
// handshake_protocol_monitor
//
// Passive valid/ready protocol checker for NUM_CH independent stream
// channels. It drives nothing on the monitored bus.
//
// Handshake semantics being checked: a beat transfers on any cycle where
// valid and ready are both high. Once valid is high without ready, the
// source must hold valid high and keep data constant until ready arrives.
// If MAX_STALL is non-zero, ready must arrive within MAX_STALL stalled
// cycles, counting the cycle valid was first raised.
//
// Ports
//   clk             : single clock, all state on posedge
//   reset           : synchronous, active-high
//   valid, ready    : per-channel handshake signals
//   data            : payloads, channel i at [i*DATA_W +: DATA_W]
//   err_clear       : clears sticky flags and viol_count
//   err_valid_drop  : sticky, valid deasserted before ready
//   err_data_change : sticky, data changed while stalled
//   err_timeout     : sticky, stall reached MAX_STALL
//   err_any         : OR of every sticky flag
//   xfer_count      : completed handshakes per channel (wraps),
//                     channel i at [i*CNT_W +: CNT_W]
//   viol_count      : total violation events, saturates at all-ones
// ---------------------------------------------------------------------------
module handshake_protocol_monitor #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_STALL = 16,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        valid,
  input  logic [NUM_CH-1:0]        ready,
  input  logic [NUM_CH*DATA_W-1:0] data,
  input  logic                     err_clear,
  output logic [NUM_CH-1:0]        err_valid_drop,
  output logic [NUM_CH-1:0]        err_data_change,
  output logic [NUM_CH-1:0]        err_timeout,
  output logic                     err_any,
  output logic [NUM_CH*CNT_W-1:0]  xfer_count,
  output logic [CNT_W-1:0]         viol_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam int STALL_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  // A channel can raise at most two events in one cycle (data change plus
  // timeout), so 2*NUM_CH bounds the per-cycle event count.
  localparam int EV_W    = $clog2(2 * NUM_CH + 1);
  localparam int SUM_W   = CNT_W + EV_W;

  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MAX_STALL);
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   VIOL_MAX  = '1;

  // Per-channel FSM state, one bit per channel (IDLE/WAIT)
  logic [NUM_CH-1:0]  state_q;
  logic [DATA_W-1:0]  snap_q  [NUM_CH];
  logic [STALL_W-1:0] stall_q [NUM_CH];
  // Remembers that this WAIT episode already reported its timeout; the
  // stall counter alone cannot tell because it saturates at MAX_STALL.
  logic [NUM_CH-1:0]  fired_q;
  logic [CNT_W-1:0]   xfer_q  [NUM_CH];

  logic [NUM_CH-1:0]  ev_drop;
  logic [NUM_CH-1:0]  ev_change;
  logic [NUM_CH-1:0]  ev_timeout;
  logic [NUM_CH-1:0]  do_xfer;
  logic [EV_W-1:0]    ev_sum;
  logic [CNT_W-1:0]   viol_base;
  logic [SUM_W-1:0]   viol_sum;
  logic [CNT_W-1:0]   viol_next;

  // Event decode for the current cycle
  always_comb begin
    ev_drop    = '0;
    ev_change  = '0;
    ev_timeout = '0;
    do_xfer    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state_q[i] == ST_WAIT) begin
        if (!valid[i]) begin
          // Data is meaningless once valid drops, so it is not compared.
          ev_drop[i] = 1'b1;
        end else begin
          if (data[i*DATA_W +: DATA_W] != snap_q[i]) ev_change[i] = 1'b1;
          if (ready[i]) begin
            do_xfer[i] = 1'b1;
          end else if ((MAX_STALL != 0) && (stall_q[i] == STALL_MAX) && !fired_q[i]) begin
            ev_timeout[i] = 1'b1;
          end
        end
      end else if (valid[i] && ready[i]) begin
        do_xfer[i] = 1'b1;
      end
    end
  end

  // Violation count: a same-cycle clear restarts from zero but still
  // records this cycle's events.
  always_comb begin
    ev_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ev_sum = ev_sum + EV_W'(ev_drop[i]) + EV_W'(ev_change[i]) + EV_W'(ev_timeout[i]);
    end
    viol_base = err_clear ? '0 : viol_count;
    viol_sum  = SUM_W'(viol_base) + SUM_W'(ev_sum);
    viol_next = (viol_sum > SUM_W'(VIOL_MAX)) ? VIOL_MAX : viol_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= {NUM_CH{ST_IDLE}};
      fired_q         <= '0;
      err_valid_drop  <= '0;
      err_data_change <= '0;
      err_timeout     <= '0;
      viol_count      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_q[i]  <= '0;
        stall_q[i] <= '0;
        xfer_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        case (state_q[i])
          ST_IDLE: begin
            if (valid[i] && !ready[i]) begin
              snap_q[i]  <= data[i*DATA_W +: DATA_W];
              stall_q[i] <= STALL_ONE;  // entry cycle is the first stall cycle
              fired_q[i] <= 1'b0;
              state_q[i] <= ST_WAIT;
            end
          end
          default: begin
            if (!valid[i]) begin
              state_q[i] <= ST_IDLE;
            end else begin
              // Track the new value so each further change flags again.
              if (ev_change[i]) snap_q[i] <= data[i*DATA_W +: DATA_W];
              if (ready[i]) begin
                state_q[i] <= ST_IDLE;
              end else begin
                if ((MAX_STALL != 0) && (stall_q[i] != STALL_MAX)) begin
                  stall_q[i] <= stall_q[i] + STALL_ONE;
                end
                if (ev_timeout[i]) fired_q[i] <= 1'b1;
              end
            end
          end
        endcase
        if (do_xfer[i]) xfer_q[i] <= xfer_q[i] + CNT_ONE;
      end
      err_valid_drop  <= (err_clear ? '0 : err_valid_drop)  | ev_drop;
      err_data_change <= (err_clear ? '0 : err_data_change) | ev_change;
      err_timeout     <= (err_clear ? '0 : err_timeout)     | ev_timeout;
      viol_count      <= viol_next;
    end
  end

  assign err_any = |{err_valid_drop, err_data_change, err_timeout};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_xfer_pack
    assign xfer_count[g*CNT_W +: CNT_W] = xfer_q[g];
  end

endmodule

// File: tb/tb_handshake_protocol_monitor.sv
// ---------------------------------------------------------------------------
// tb_handshake_protocol_monitor
//
// Directed bench for handshake_protocol_monitor with default parameters
// (NUM_CH=4, DATA_W=32, MAX_STALL=16, CNT_W=16). Expected values are queued
// as each stimulus step is driven and popped when the result is sampled,
// 1 time unit after the clock edge that produced it.
// ---------------------------------------------------------------------------
module tb_handshake_protocol_monitor;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 32;
  localparam int MAX_STALL = 16;
  localparam int CNT_W     = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset;
  logic [NUM_CH-1:0]        valid;
  logic [NUM_CH-1:0]        ready;
  logic [NUM_CH*DATA_W-1:0] data;
  logic                     err_clear;
  logic [NUM_CH-1:0]        err_valid_drop;
  logic [NUM_CH-1:0]        err_data_change;
  logic [NUM_CH-1:0]        err_timeout;
  logic                     err_any;
  logic [NUM_CH*CNT_W-1:0]  xfer_count;
  logic [CNT_W-1:0]         viol_count;

  handshake_protocol_monitor #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .MAX_STALL(MAX_STALL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .valid(valid),
    .ready(ready),
    .data(data),
    .err_clear(err_clear),
    .err_valid_drop(err_valid_drop),
    .err_data_change(err_data_change),
    .err_timeout(err_timeout),
    .err_any(err_any),
    .xfer_count(xfer_count),
    .viol_count(viol_count)
  );

  // ---------------- scoreboard ----------------
  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];

  task automatic push_exp(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [63:0] obs);
    logic [63:0] exp_v;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed=%0h, no expected value queued", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic v, input logic r, input logic [DATA_W-1:0] d);
    valid[ch] = v;
    ready[ch] = r;
    data[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  function automatic logic [CNT_W-1:0] xfer_of(input int ch);
    return xfer_count[ch*CNT_W +: CNT_W];
  endfunction

  // ---------------- directed sequence ----------------
  logic [DATA_W-1:0] d1, d2;

  initial begin
    reset = 1'b1; valid = '0; ready = '0; data = '0; err_clear = 1'b0;
    tick(); tick();
    push_exp(0); push_exp(0); push_exp(0); push_exp(0);
    check("reset_err_any", err_any);
    check("reset_viol", viol_count);
    check("reset_xfer", xfer_count);
    check("reset_flags", {err_valid_drop, err_data_change, err_timeout});
    reset = 1'b0;

    // T1: clean stall of three cycles then transfer on ch0
    drive(0, 1'b1, 1'b0, 32'hA5A5_0001);
    tick(); tick(); tick();
    drive(0, 1'b1, 1'b1, 32'hA5A5_0001);
    push_exp(1); push_exp(0); push_exp(0);
    tick();
    drive(0, 1'b0, 1'b0, '0);
    check("t1_xfer0", xfer_of(0));
    check("t1_err_any", err_any);
    check("t1_viol", viol_count);

    // T2: data changes on the second stalled cycle of ch1
    drive(1, 1'b1, 1'b0, 32'h10);
    tick();
    drive(1, 1'b1, 1'b0, 32'h11);
    tick(); tick();
    drive(1, 1'b1, 1'b1, 32'h11);
    push_exp(4'b0010); push_exp(1); push_exp(1); push_exp(1);
    tick();
    drive(1, 1'b0, 1'b0, '0);
    check("t2_data_change", err_data_change);
    check("t2_viol", viol_count);
    check("t2_xfer1", xfer_of(1));
    check("t2_err_any", err_any);

    push_exp(0); push_exp(0);
    pulse_clear();
    check("clr_viol", viol_count);
    check("clr_err_any", err_any);

    // T3: ch2 drops valid after one stall cycle, then a fresh episode
    d1 = 32'($urandom_range(32'h7FFF_FFFF, 0));
    d2 = d1 ^ 32'h0000_0100;
    drive(2, 1'b1, 1'b0, d1);
    tick();
    drive(2, 1'b0, 1'b0, d1);
    push_exp(4'b0100); push_exp(1);
    tick();
    check("t3_valid_drop", err_valid_drop);
    check("t3_viol", viol_count);
    drive(2, 1'b1, 1'b0, d2);
    tick();
    drive(2, 1'b1, 1'b1, d2);
    push_exp(0); push_exp(1); push_exp(1);
    tick();
    drive(2, 1'b0, 1'b0, '0);
    check("t3_restart_no_change", err_data_change);
    check("t3_xfer2", xfer_of(2));
    check("t3_viol_after", viol_count);
    pulse_clear();

    // T4: ch3 stalls 20 cycles; timeout visible after the 17th edge
    d1 = 32'($urandom_range(32'hFFFF, 0));
    drive(3, 1'b1, 1'b0, d1);
    for (int i = 0; i < MAX_STALL; i++) tick();
    push_exp(0);
    check("t4_no_timeout_yet", err_timeout);
    tick();
    push_exp(4'b1000);
    check("t4_timeout", err_timeout);
    tick(); tick(); tick();
    push_exp(1);
    check("t4_viol_once", viol_count);
    drive(3, 1'b1, 1'b1, d1);
    push_exp(1);
    tick();
    drive(3, 1'b0, 1'b0, '0);
    check("t4_xfer3", xfer_of(3));
    pulse_clear();

    // T4b: ready on stall cycle 16 is legal
    drive(3, 1'b1, 1'b0, d1);
    for (int i = 0; i < MAX_STALL - 1; i++) tick();
    drive(3, 1'b1, 1'b1, d1);
    push_exp(0); push_exp(0); push_exp(2);
    tick();
    drive(3, 1'b0, 1'b0, '0);
    check("t4b_no_timeout", err_timeout);
    check("t4b_viol", viol_count);
    check("t4b_xfer3", xfer_of(3));

    // T5: build viol_count to 5, then two drops coincide with err_clear
    for (int c = 0; c < NUM_CH; c++) drive(c, 1'b1, 1'b0, 32'($urandom_range(1000, 0)));
    tick();
    for (int c = 0; c < NUM_CH; c++) drive(c, 1'b0, 1'b0, '0);
    tick();
    drive(2, 1'b1, 1'b0, 32'h55);
    tick();
    drive(2, 1'b0, 1'b0, '0);
    push_exp(5);
    tick();
    check("t5_viol_pre", viol_count);
    drive(0, 1'b1, 1'b0, 32'h1234);
    drive(1, 1'b1, 1'b0, 32'h5678);
    tick();
    drive(0, 1'b0, 1'b0, '0);
    drive(1, 1'b0, 1'b0, '0);
    push_exp(4'b0011); push_exp(2); push_exp(0);
    pulse_clear();
    check("t5_drop_flags", err_valid_drop);
    check("t5_viol", viol_count);
    check("t5_other_flags", {err_data_change, err_timeout});

    // T6: reset mid-stall, then four back-to-back transfers on ch0
    drive(0, 1'b1, 1'b0, 32'hCAFE);
    tick();
    reset = 1'b1;
    push_exp(0); push_exp(0); push_exp(0);
    tick();
    check("t6_reset_err_any", err_any);
    check("t6_reset_viol", viol_count);
    check("t6_reset_xfer", xfer_count);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 1'b1, 32'($urandom_range(32'hFFFF, 0)));
      tick();
    end
    drive(0, 1'b0, 1'b0, '0);
    push_exp(4); push_exp(0); push_exp(0);
    check("t6_xfer0", xfer_of(0));
    check("t6_err_any", err_any);
    check("t6_viol", viol_count);

    // ---------------- final report ----------------
    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL leftover_expected: observed=%0d entries, expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
